// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router output FIFOs.
// Header layout: payload length in [7:2], destination port in [1:0].
package router_pkg;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 16;
   localparam int LEN_MSB   = 7;
   localparam int LEN_LSB   = 2;
   localparam int ADDR_MSB  = 1;
   localparam int ADDR_LSB  = 0;
   localparam int PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one router output FIFO.
// One write port; unregistered read port, registered by the parent.
module router_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [DATA_W:0] wdata_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [DATA_W:0] rdata_o
);

   logic [DATA_W:0] mem_q [DEPTH];

   // Contents are never cleared; reset only moves the pointers.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router with header flag
// and packet-boundary tracking.
module router_fifo #(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int DEPTH  = router_pkg::DEPTH
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enb,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              pkt_busy,
   output logic              full,
   output logic              empty
);

   import router_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 push, pop;
   logic [DATA_W:0]      rd_word;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign push = write_enb && !full && !soft_reset;
   assign pop  = read_enb && !empty && !soft_reset;

   router_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i   (clock),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i ({lfd_state, data_in}),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_word)
   );

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pkt_cnt_d = pkt_cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      if (soft_reset) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         pkt_cnt_d = '0;
         data_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            data_d   = rd_word[DATA_W-1:0];
            valid_d  = 1'b1;
            // Header reload covers the payload plus the parity byte.
            if (rd_word[DATA_W]) begin
               pkt_cnt_d = PKT_CNT_W'(rd_word[LEN_MSB:LEN_LSB])
                         + PKT_CNT_W'(1);
            end else if (pkt_cnt_q != '0) begin
               pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pkt_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign pkt_busy  = (pkt_cnt_q != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo against a queue-based
// model of the packet FIFO.
module tb_router_fifo;

   localparam int DEPTH = 16;

   logic       clock;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic       read_enb;
   logic [7:0] data_out;
   logic       valid_out;
   logic       pkt_busy;
   logic       full;
   logic       empty;

   int passed = 0;
   int total  = 0;

   logic [8:0] mq [$];
   logic [7:0] m_data;
   logic       m_valid;
   int         m_cnt;

   router_fifo dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .read_enb   (read_enb),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .pkt_busy   (pkt_busy),
      .full       (full),
      .empty      (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_clear();
      mq.delete();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_cnt   = 0;
   endtask

   // Drive one cycle of stimulus, advance the model, settle at edge+1.
   task automatic step(input logic we, input logic lfd,
                       input logic [7:0] din, input logic re,
                       input logic sr);
      logic       was_full, was_empty;
      logic [8:0] e;
      write_enb  = we;
      lfd_state  = lfd;
      data_in    = din;
      read_enb   = re;
      soft_reset = sr;
      @(posedge clock);
      if (sr) begin
         model_clear();
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         m_valid   = 1'b0;
         if (re && !was_empty) begin
            e       = mq.pop_front();
            m_data  = e[7:0];
            m_valid = 1'b1;
            if (e[8]) m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end
         if (we && !was_full) mq.push_back({lfd, din});
      end
      #1;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      soft_reset = 1'b0;
      lfd_state  = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty);
      else passed++;
      total++;
      if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full);
      else passed++;
      total++;
      if (data_out !== 8'h00)
         $display("FAIL reset_data got %h exp 00", data_out);
      else passed++;
      total++;
      if (valid_out !== 1'b0)
         $display("FAIL reset_valid got %b exp 0", valid_out);
      else passed++;
      total++;
      if (pkt_busy !== 1'b0)
         $display("FAIL reset_busy got %b exp 0", pkt_busy);
      else passed++;
      resetn = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_packet();
      logic [7:0] pkt [5];
      logic       bsy [5];
      pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
      bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) step(1'b1, i == 0, pkt[i], 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (data_out !== pkt[i] || valid_out !== 1'b1)
            $display("FAIL single_data[%0d] got %h/%b exp %h/1",
                     i, data_out, valid_out, pkt[i]);
         else passed++;
         total++;
         if (pkt_busy !== bsy[i])
            $display("FAIL single_busy[%0d] got %b exp %b",
                     i, pkt_busy, bsy[i]);
         else passed++;
      end
      total++;
      if (empty !== 1'b1) $display("FAIL single_empty got %b exp 1", empty);
      else passed++;
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      total++;
      if (full !== 1'b1) $display("FAIL full_set got %b exp 1", full);
      else passed++;
      step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
      total++;
      if (full !== 1'b1) $display("FAIL full_drop got %b exp 1", full);
      else passed++;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (data_out !== 8'(i) || valid_out !== 1'b1)
            $display("FAIL full_pop[%0d] got %h/%b exp %h/1",
                     i, data_out, valid_out, 8'(i));
         else passed++;
      end
      total++;
      if (empty !== 1'b1) $display("FAIL full_empty got %b exp 1", empty);
      else passed++;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'h0F || valid_out !== 1'b0)
         $display("FAIL empty_pop got %h/%b exp 0f/0", data_out, valid_out);
      else passed++;
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'h50 || valid_out !== 1'b1 || full !== 1'b0)
         $display("FAIL sim_full got %h/%b/%b exp 50/1/0",
                  data_out, valid_out, full);
      else passed++;
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (data_out !== 8'h50 + 8'(i))
            $display("FAIL sim_drain[%0d] got %h exp %h",
                     i, data_out, 8'h50 + 8'(i));
         else passed++;
      end
      total++;
      if (empty !== 1'b1)
         $display("FAIL sim_bb_dropped got empty=%b exp 1", empty);
      else passed++;
      step(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
      total++;
      if (valid_out !== 1'b0 || empty !== 1'b0)
         $display("FAIL sim_empty got valid=%b empty=%b exp 0/0",
                  valid_out, empty);
      else passed++;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'hCC || valid_out !== 1'b1)
         $display("FAIL sim_cc got %h/%b exp cc/1", data_out, valid_out);
      else passed++;
   endtask

   task automatic test_soft_reset();
      step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (pkt_busy !== 1'b1 || data_out !== 8'h11)
         $display("FAIL srst_pre got busy=%b data=%h exp 1/11",
                  pkt_busy, data_out);
      else passed++;
      step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
      total++;
      if (empty !== 1'b1 || pkt_busy !== 1'b0 ||
          data_out !== 8'h00 || valid_out !== 1'b0)
         $display("FAIL srst got e=%b b=%b d=%h v=%b exp 1/0/00/0",
                  empty, pkt_busy, data_out, valid_out);
      else passed++;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (valid_out !== 1'b0 || empty !== 1'b1)
         $display("FAIL srst_ee_dropped got v=%b e=%b exp 0/1",
                  valid_out, empty);
      else passed++;
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int expn   = 0;
      int occ;
      logic we, re;
      for (int it = 0; it < 400; it++) begin
         if (pushed >= 40 && mq.size() == 0) break;
         occ = mq.size();
         if (pushed < 40) begin
            we = (occ < 3) ? 1'b1 : (occ >= 10) ? 1'b0 : 1'($urandom_range(0, 1));
            re = (occ <= 3) ? 1'b0 : (occ >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
         end else begin
            we = 1'b0;
            re = (occ > 0);
         end
         step(we, 1'b0, 8'(pushed), re, 1'b0);
         if (we) pushed++;
         if (re) begin
            total++;
            if (data_out !== 8'(expn) || valid_out !== 1'b1)
               $display("FAIL wrap_pop[%0d] got %h/%b exp %h/1",
                        expn, data_out, valid_out, 8'(expn));
            else passed++;
            expn++;
         end
         total++;
         if (full !== 1'b0) $display("FAIL wrap_full got %b exp 0", full);
         else passed++;
      end
      total++;
      if (expn != 40) $display("FAIL wrap_count got %0d exp 40", expn);
      else passed++;
   endtask

   task automatic test_random();
      logic we, re, lfd, sr;
      for (int i = 0; i < 300; i++) begin
         we  = ($urandom_range(0, 2) != 0);
         re  = 1'($urandom_range(0, 1));
         lfd = ($urandom_range(0, 7) == 0);
         sr  = ($urandom_range(0, 63) == 0);
         step(we, lfd, 8'($urandom), re, sr);
         total++;
         if (valid_out !== m_valid || data_out !== m_data ||
             pkt_busy !== (m_cnt != 0) ||
             full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0))
            $display("FAIL rand[%0d] got d=%h v=%b b=%b f=%b e=%b exp d=%h v=%b b=%b f=%b e=%b",
                     i, data_out, valid_out, pkt_busy, full, empty,
                     m_data, m_valid, m_cnt != 0,
                     mq.size() == DEPTH, mq.size() == 0);
         else passed++;
      end
   endtask

   initial begin
      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      lfd_state  = 1'b0;
      data_in    = 8'h00;
      read_enb   = 1'b0;
      #1;
      test_reset();
      test_single_packet();
      test_full();
      test_simultaneous();
      test_soft_reset();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO of the 1x3 router. It buffers the bytes of one packet destined for a single output port, from the header through the payload to the parity byte. Three instances sit downstream of the router synchronizer (`router_sync`), which supplies each instance's `write_enb` and `soft_reset`. Each instance drains to its output port through `read_enb`, and tracks the packet boundary so the port knows when a packet is still in flight.

## Interface
- `DATA_W`, 8: byte width.
- `DEPTH`, 16: entries; must be a power of 2.
- `clock`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `soft_reset`  in  1: synchronous flush, from `router_sync` on read timeout.
- `write_enb`  in  1: push request.
- `lfd_state`  in  1: marks `data_in` as a header byte; sampled with the push.
- `data_in`  in  DATA_W: byte to push.
- `read_enb`  in  1: pop request.
- `data_out`  out  DATA_W: registered popped byte.
- `valid_out`  out  1: `data_out` updated this cycle.
- `pkt_busy`  out  1: the current packet has unread bytes left.
- `full`  out  1: all DEPTH entries are occupied.
- `empty`  out  1: no entries are occupied.

## Operation
- **Storage:** DEPTH words of DATA_W+1 bits. Bit DATA_W holds the header flag, captured from `lfd_state` at the push.
- **Pointers:** `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits each.
  - `empty` = pointers equal.
  - `full` = MSBs differ and all lower bits equal.
- **Push:** when `write_enb && !full`, store {`lfd_state`, `data_in`} at `wr_ptr` and increment `wr_ptr`. A push while full is dropped silently.
- **Pop:** when `read_enb && !empty`:
  - `data_out` takes the stored byte.
  - `valid_out` is 1 for that one cycle.
  - `rd_ptr` increments.
  - A pop while empty is ignored: `data_out` holds its value and `valid_out` is 0.
- **Packet counter** (`pkt_cnt`, 7 bits):
  - Popped entry has the header flag set: load `data[7:2] + 1` (payload length plus the parity byte).
  - Popped entry is not a header and `pkt_cnt != 0`: decrement.
  - `pkt_busy` = (`pkt_cnt != 0`).
- **Simultaneous push and pop:** both proceed independently, each gated by the pre-edge `full`/`empty`.
  - At full: the pop occurs and the push is dropped.
  - At empty: the push occurs and the pop is ignored.
- **Priority:** `resetn` > `soft_reset` > push/pop. When `soft_reset` is 1, push and pop in the same cycle are discarded.
- **Effect of `soft_reset` or `resetn`:**
  - Pointers go to 0 and `pkt_cnt` goes to 0.
  - `data_out` = 0 and `valid_out` = 0.
  - Memory contents are not cleared; they are unreachable once the pointers reset.
- **Reset values:** `data_out`=0, `valid_out`=0, `pkt_busy`=0, `full`=0, `empty`=1.
- **Wrap-around:** pointers wrap naturally modulo 2·DEPTH. Byte order is preserved across the wrap.

## Timing
- Pop latency: `data_out` and `valid_out` update on the edge at which the pop is accepted, so they are visible 1 cycle after `read_enb` was sampled.
- `full` and `empty` are combinational from the registered pointers. They reflect a push or pop starting the cycle after the edge that performed it.
- `pkt_busy` is valid in the same cycle as the `data_out` it describes.
- `soft_reset` takes effect at the next rising edge. All outputs are at their reset values in the following cycle.
- Asynchronous `resetn` assertion clears state immediately, independent of the clock. Deassertion is expected to be synchronized externally.

## Structure
- **Shared package `router_pkg`:**
  - `DATA_W`, `DEPTH`.
  - Header field positions: length = [7:2], address = [1:0].
  - The packet-counter width.
- **Sub-module `router_fifo_mem`:** DEPTH x (DATA_W+1), one write port, one unregistered read port. `router_fifo` registers the read data.
- All other logic (pointers, flags, packet counter, `data_out` register) lives inline in `router_fifo`.

## Test plan
1. **Reset:** hold `resetn`=0 for 2 cycles → `empty`=1, `full`=0, `data_out`=0, `valid_out`=0, `pkt_busy`=0.
2. **Single packet:**
   - Stimulus: push 0x0D with `lfd_state`=1, then 0x11, 0x22, 0x33 and parity 0x44; then pop 5 times.
   - Data: `data_out` = 0D, 11, 22, 33, 44, each 1 cycle after its `read_enb`, with `valid_out`=1.
   - `pkt_busy`: 1 from the header pop through the 0x33 pop, 0 after the 0x44 pop.
   - End state: `empty`=1.
3. **Full:**
   - Push 0x00–0x0F → `full`=1 after the 16th push.
   - A 17th push of 0xAA is dropped.
   - 16 pops return 0x00–0x0F in order, then `empty`=1.
   - A further pop keeps `data_out`=0x0F with `valid_out`=0.
4. **Simultaneous at boundaries:**
   - At full, push 0xBB and pop together → pop returns the oldest byte, 0xBB is not stored, `full`=0.
   - At empty, push 0xCC and pop together → pop ignored, `empty`=0, next pop returns 0xCC.
5. **Soft reset mid-packet:**
   - Push header 0x11 and 2 payload bytes; pop the header so `pkt_busy`=1.
   - Assert `soft_reset` for 1 cycle together with a push of 0xEE.
   - Result: `empty`=1, `pkt_busy`=0, `data_out`=0, and 0xEE is not stored.
6. **Wrap:** interleave 40 pushes of 0x00–0x27 with pops, keeping occupancy between 3 and 10 → pops return 0x00–0x27 in exact order, and `full` never asserts.
